// File: rtl/bin_to_bcd_param.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_param
// Multi-cycle binary-to-BCD converter (shift-and-add-3, one bit per clock).
// It sits between the weighing-scale weight accumulator and the 7-segment
// display driver.
//
// Parameters:
//   BIN_W   binary input width (>= 1)
//   DIGITS  number of BCD output digits (>= 1)
//
// Ports:
//   CLK     rising-edge clock
//   RST     asynchronous, active-high reset
//   START   conversion request; sampled only while idle
//   BIN     unsigned input value, captured on the edge that accepts START
//   BCDOUT  result; digit 0 (units) is in [3:0]
//   BUSY    high while a conversion is in progress
//   DONE    one-cycle pulse when BCDOUT/OVF have just been updated
//   OVF     captured BIN >= 10**DIGITS; valid alongside BCDOUT
//
// Build option:
//   BIN2BCD_SATURATE_EN  when defined, an overflowing result shows all nines
//                        instead of BIN mod 10**DIGITS. OVF is the same either way.
// -----------------------------------------------------------------------------
module bin_to_bcd_param #(
   parameter int BIN_W  = 16,
   parameter int DIGITS = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  START,
   input  logic [BIN_W-1:0]      BIN,
   output logic [4*DIGITS-1:0]   BCDOUT,
   output logic                  BUSY,
   output logic                  DONE,
   output logic                  OVF
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      FINISH
   } state_t;

   state_t             state;
   logic [BIN_W-1:0]   bin_reg;
   logic [BCD_W-1:0]   scratch;
   logic               sticky_ovf;
   logic [CNT_W-1:0]   count;

   // Per-digit add-3 correction. Each nibble is corrected on its own; a
   // corrected digit is at most 12, so no carry crosses a digit boundary.
   logic [BCD_W-1:0]   adjusted;

   always_comb begin
      // NOTE: give every combinational output a default first so no path
      // leaves it unassigned; otherwise a latch is inferred.
      adjusted = scratch;
      for (int i = 0; i < DIGITS; i++) begin
         if (scratch[4*i +: 4] >= 4'd5)
            adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
   end

   // NOTE: state registers use non-blocking assignments so that every
   // register samples the values from before the edge, whatever the order
   // of the statements.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= IDLE;
         bin_reg    <= '0;
         scratch    <= '0;
         sticky_ovf <= 1'b0;
         count      <= '0;
         BCDOUT     <= '0;
         BUSY       <= 1'b0;
         DONE       <= 1'b0;
         OVF        <= 1'b0;
      end else begin
         DONE <= 1'b0;
         unique case (state)
            IDLE: begin
               if (START) begin
                  bin_reg    <= BIN;
                  scratch    <= '0;
                  sticky_ovf <= 1'b0;
                  count      <= '0;
                  BUSY       <= 1'b1;
                  state      <= CONV;
               end
            end

            CONV: begin
               // Shift {scratch, bin_reg} left by one. Whatever leaves the
               // top digit would be the carry into digit DIGITS, so any 1
               // seen here means the value does not fit in DIGITS digits.
               scratch    <= {adjusted[BCD_W-2:0], bin_reg[BIN_W-1]};
               bin_reg    <= bin_reg << 1;
               sticky_ovf <= sticky_ovf | adjusted[BCD_W-1];
               count      <= count + CNT_W'(1);
               if (count == CNT_W'(BIN_W - 1))
                  state <= FINISH;
            end

            FINISH: begin
`ifdef BIN2BCD_SATURATE_EN
               BCDOUT <= sticky_ovf ? {DIGITS{4'h9}} : scratch;
`else
               BCDOUT <= scratch;
`endif
               OVF   <= sticky_ovf;
               DONE  <= 1'b1;
               BUSY  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               BUSY  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bin_to_bcd_param.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_param
// Self-checking bench for bin_to_bcd_param. Three instances share the clock
// and reset: A (BIN_W=16, DIGITS=4), B (BIN_W=16, DIGITS=5) and
// C (BIN_W=8, DIGITS=2). Expected results come from an arithmetic model
// (modulo and division by ten), so they are independent of the shift-and-add
// datapath. Honours BIN2BCD_SATURATE_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_param;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [2:0]  start = '0;
   logic [15:0] bin_a = '0, bin_b = '0;
   logic [7:0]  bin_c = '0;
   logic [15:0] bcd_a;
   logic [19:0] bcd_b;
   logic [7:0]  bcd_c;
   logic [2:0]  busy, done, ovf;

   int tests  = 0;
   int failed = 0;

   always #5 CLK = ~CLK;

   bin_to_bcd_param #(.BIN_W(16), .DIGITS(4)) u_a (
      .CLK(CLK), .RST(RST), .START(start[0]), .BIN(bin_a),
      .BCDOUT(bcd_a), .BUSY(busy[0]), .DONE(done[0]), .OVF(ovf[0]));

   bin_to_bcd_param #(.BIN_W(16), .DIGITS(5)) u_b (
      .CLK(CLK), .RST(RST), .START(start[1]), .BIN(bin_b),
      .BCDOUT(bcd_b), .BUSY(busy[1]), .DONE(done[1]), .OVF(ovf[1]));

   bin_to_bcd_param #(.BIN_W(8), .DIGITS(2)) u_c (
      .CLK(CLK), .RST(RST), .START(start[2]), .BIN(bin_c),
      .BCDOUT(bcd_c), .BUSY(busy[2]), .DONE(done[2]), .OVF(ovf[2]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic int digits_of(input int k);
      return (k == 0) ? 4 : (k == 1) ? 5 : 2;
   endfunction

   function automatic int width_of(input int k);
      return (k == 2) ? 8 : 16;
   endfunction

   function automatic logic [19:0] bcd_of(input int k);
      case (k)
         0:       return {4'h0, bcd_a};
         1:       return bcd_b;
         default: return {12'h0, bcd_c};
      endcase
   endfunction

   task automatic drive(input int k, input logic s, input longint v);
      start[k] = s;
      case (k)
         0:       bin_a = v[15:0];
         1:       bin_b = v[15:0];
         default: bin_c = v[7:0];
      endcase
   endtask

   // Reference: decimal digits of v mod 10**digits, overflow if v doesn't fit.
   function automatic void model(input longint v, input int digits,
                                 output logic [19:0] bcd, output logic of);
      longint p = 1;
      longint m;
      for (int i = 0; i < digits; i++) p = p * 10;
      of  = (v >= p);
      m   = v % p;
      bcd = '0;
      for (int i = 0; i < digits; i++) begin
`ifdef BIN2BCD_SATURATE_EN
         bcd[4*i +: 4] = of ? 4'd9 : 4'(m % 10);
`else
         bcd[4*i +: 4] = 4'(m % 10);
`endif
         m = m / 10;
      end
   endfunction

   // One full conversion on instance k: request, accept, scramble BIN while
   // busy, then measure accept-to-DONE latency and check the result.
   task automatic run(input int k, input longint v, input string tag);
      logic [19:0] exp_bcd;
      logic        exp_ovf;
      int          n = 0;
      model(v, digits_of(k), exp_bcd, exp_ovf);
      @(negedge CLK);
      drive(k, 1'b1, v);
      @(posedge CLK);
      #1;
      drive(k, 1'b0, longint'($urandom));
      check({tag, "_busy"}, busy[k], 1'b1);
      check({tag, "_done_drop"}, done[k], 1'b0);
      while (n < 40 && !done[k]) begin
         @(posedge CLK);
         #1;
         n++;
      end
      check({tag, "_latency"}, n, width_of(k) + 1);
      check({tag, "_bcd"}, bcd_of(k), exp_bcd);
      check({tag, "_ovf"}, ovf[k], exp_ovf);
      check({tag, "_busy_low"}, busy[k], 1'b0);
   endtask

   initial begin
      logic [19:0] exp_bcd;
      logic        exp_ovf;
      int          n;

      // Reset state, observed while reset is held.
      #2;
      check("rst_bcd", bcd_of(0), 20'h0);
      check("rst_busy", busy[0], 1'b0);
      check("rst_done", done[0], 1'b0);
      check("rst_ovf", ovf[0], 1'b0);
      @(negedge CLK);
      RST = 1'b0;

      // Basic and boundary values.
      run(0, 2, "basic");
      run(0, 9999, "max4");
      run(0, 0, "zero");
      run(0, 10000, "ovf10k");
      run(0, 65535, "ovf_max");

      // START pulsed 5 cycles after accept with a different BIN is ignored.
      model(3141, 4, exp_bcd, exp_ovf);
      @(negedge CLK);
      drive(0, 1'b1, 3141);
      @(posedge CLK);
      #1;
      drive(0, 1'b0, 3141);
      repeat (5) @(posedge CLK);
      #1;
      drive(0, 1'b1, 777);
      @(posedge CLK);
      #1;
      drive(0, 1'b0, 0);
      n = 6;
      while (n < 40 && !done[0]) begin
         @(posedge CLK);
         #1;
         n++;
      end
      check("ignore_latency", n, 17);
      check("ignore_bcd", bcd_of(0), exp_bcd);

      // START in the DONE cycle: run() requests on the next negedge, which
      // is still inside the DONE cycle left by the previous conversion.
      check("done_cycle_pre", done[0], 1'b1);
      run(0, 1234, "back2back");

      // Reset abort at iteration 8 of a conversion of 4321.
      @(negedge CLK);
      drive(0, 1'b1, 4321);
      @(posedge CLK);
      #1;
      drive(0, 1'b0, 0);
      repeat (8) @(posedge CLK);
      #1;
      RST = 1'b1;
      #1;
      check("abort_bcd", bcd_of(0), 20'h0);
      check("abort_ovf", ovf[0], 1'b0);
      check("abort_busy", busy[0], 1'b0);
      @(negedge CLK);
      RST = 1'b0;
      n = 0;
      repeat (25) begin
         @(posedge CLK);
         #1;
         if (done[0]) n++;
      end
      check("abort_no_done", n, 0);
      run(0, 42, "after_abort");

      // Parameter sweep.
      run(1, 65535, "d5_max");
      run(2, 200, "w8_ovf");
      run(2, 99, "w8_max");

      // Randomized values on every instance.
      for (int i = 0; i < 20; i++) begin
         run(0, longint'($urandom_range(65535)), "rand_a");
         run(1, longint'($urandom_range(65535)), "rand_b");
         run(2, longint'($urandom_range(255)), "rand_c");
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
